apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_arb_pkg.sv | 14 +
 rtl/apb_rr_select.sv | 27 ++
 rtl/apb_req_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter: FSM state encoding
// and the width of the one-hot PSEL decode.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int PSEL_W = 16;
  localparam int SEL_W  = 4;

endpackage

// File: rtl/apb_rr_select.sv
// Round-robin grant selection: the first set request at or after ptr, wrapping
// from NREQ-1 back to 0, is returned as a one-hot grant (all zero if no request).
module apb_rr_select #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the nearest hit overwrites earlier ones.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Multi-requester APB master: round-robin arbitration into an IDLE/SETUP/ACCESS
// transfer FSM. Define APB_REQ_ARBITER_TIMEOUT_EN to bound the ACCESS wait.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int SEL_LSB = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      REQ_WRITE,
  input  logic [NREQ*32-1:0]   REQ_ADDR,
  input  logic [NREQ*32-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]      DONE,
  output logic [31:0]          RDATA,
  output logic                 ERR,
  output logic [31:0]          PADDR,
  output logic [PSEL_W-1:0]    PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR,
  output logic                 BUSY
);

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("apb_req_arbiter: NREQ must be 2..8");
  end
  if (SEL_LSB < 0 || SEL_LSB + SEL_W > 32) begin : g_bad_sel
    $error("apb_req_arbiter: SEL_LSB field must lie inside PADDR");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_to
    $error("apb_req_arbiter: TIMEOUT must be 1..65535");
  end

  apb_state_e          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [31:0]         paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic                pwrite_q, pwrite_d;
  logic [PSEL_W-1:0]   psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  logic [NREQ-1:0]     req_m;
  logic [NREQ-1:0]     sel_gnt;
  logic [31:0]         g_addr;
  logic [31:0]         g_wdata;
  logic                g_write;
  logic [PW-1:0]       g_ptr;

  // A requester being acknowledged this cycle may still have REQ high; keep it
  // out of the next grant so it cannot win twice in a row.
  assign req_m = REQ & ~done_q;

  apb_rr_select #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_select (
    .req  (req_m),
    .ptr  (ptr_q),
    .gnt  (sel_gnt)
  );

  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_write = 1'b0;
    g_ptr   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_gnt[i]) begin
        g_addr  = REQ_ADDR[i*32 +: 32];
        g_wdata = REQ_WDATA[i*32 +: 32];
        g_write = REQ_WRITE[i];
        g_ptr   = PW'((i + 1) % NREQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    done_d    = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_m) begin
          state_d  = ST_SETUP;
          gnt_d    = sel_gnt;
          ptr_d    = g_ptr;
          paddr_d  = g_addr;
          pwdata_d = g_wdata;
          pwrite_d = g_write;
          psel_d   = '0;
          psel_d[g_addr[SEL_LSB +: SEL_W]] = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ST_ACCESS: begin
        if (PREADY) begin
          state_d   = ST_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          done_d    = gnt_q;
          rdata_d   = pwrite_q ? 32'h0 : PRDATA;
          err_d     = PSLVERR;
        end
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
          done_d    = gnt_q;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign DONE    = done_q;
  assign RDATA   = rdata_q;
  assign ERR     = err_q;
  assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: expected completions are queued when a
// request is driven and checked when DONE fires. Includes a simple APB slave.
module tb_apb_req_arbiter;

  localparam int NREQ = 4;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [NREQ-1:0]   REQ, REQ_WRITE;
  logic [NREQ*32-1:0] REQ_ADDR, REQ_WDATA;
  logic [NREQ-1:0]   DONE;
  logic [31:0]       RDATA, PADDR, PWDATA, PRDATA;
  logic              ERR, PENABLE, PWRITE, PREADY, PSLVERR, BUSY;
  logic [15:0]       PSEL;

  apb_req_arbiter #(.NREQ(NREQ), .SEL_LSB(8), .TIMEOUT(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .DONE(DONE), .RDATA(RDATA),
    .ERR(ERR), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .BUSY(BUSY)
  );

  always #5 PCLK = ~PCLK;

  // Slave: PREADY rises after wait_cfg ACCESS cycles unless hang is set.
  int          wait_cfg = 0;
  bit          hang = 1'b0;
  bit          err_cfg = 1'b0;
  logic [31:0] rd_cfg = 32'h0;
  int          acc_cnt = 0;
  always @(posedge PCLK) acc_cnt <= (PENABLE && !PREADY) ? acc_cnt + 1 : 0;
  assign PREADY  = PENABLE && !hang && (acc_cnt >= wait_cfg);
  assign PRDATA  = rd_cfg;
  assign PSLVERR = err_cfg && PREADY;

  typedef struct {int idx; logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin @(negedge PCLK); n++; end while (DONE == '0 && n < limit);
  endtask

  task automatic test_reset();
    PRESET = 1'b1; REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    repeat (2) @(negedge PCLK);
    n_chk++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got psel=%h en=%b wr=%b addr=%h wd=%h want all 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    n_chk++;
    if ({DONE, RDATA, ERR, BUSY} !== '0) begin
      n_fail++; $display("FAIL reset_status: got done=%b rdata=%h err=%b busy=%b want all 0", DONE, RDATA, ERR, BUSY);
    end
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_single_write();
    exp_t e; int n;
    wait_cfg = 0; rd_cfg = 32'hDEAD_BEEF; err_cfg = 1'b0;
    REQ_ADDR[0 +: 32] = 32'h0000_0304; REQ_WDATA[0 +: 32] = 32'hA5A5_0001;
    REQ_WRITE[0] = 1'b1; REQ[0] = 1'b1;
    sb.push_back('{0, 32'h0, 1'b0});
    @(negedge PCLK); REQ[0] = 1'b0;
    n_chk++;
    if (PSEL !== 16'h0008 || PENABLE !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++; $display("FAIL wr_setup: psel=%h en=%b busy=%b want 0008/0/1", PSEL, PENABLE, BUSY);
    end
    n_chk++;
    if (PADDR !== 32'h0000_0304 || PWRITE !== 1'b1 || PWDATA !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL wr_setup_bus: addr=%h wr=%b wd=%h", PADDR, PWRITE, PWDATA);
    end
    @(negedge PCLK);
    n_chk++;
    if (PSEL !== 16'h0008 || PENABLE !== 1'b1 || PADDR !== 32'h0000_0304 || PWDATA !== 32'hA5A5_0001) begin
      n_fail++; $display("FAIL wr_access: psel=%h en=%b addr=%h wd=%h", PSEL, PENABLE, PADDR, PWDATA);
    end
    wait_done(20, n);
    n_chk++;
    if (n + 2 !== 3) begin
      n_fail++; $display("FAIL wr_latency: got %0d cycles want 3", n + 2);
    end
    e = sb.pop_front();
    n_chk++;
    if (DONE !== (4'b1 << e.idx) || RDATA !== e.rdata || ERR !== e.err) begin
      n_fail++; $display("FAIL wr_done: done=%b rdata=%h err=%b want idx %0d rdata=%h err=%b", DONE, RDATA, ERR, e.idx, e.rdata, e.err);
    end
    @(negedge PCLK);
    n_chk++;
    if (DONE !== '0 || PSEL !== '0 || PENABLE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL wr_after: done=%b psel=%h en=%b busy=%b want all 0", DONE, PSEL, PENABLE, BUSY);
    end
  endtask

  task automatic test_read_wait();
    exp_t e; bit bad;
    wait_cfg = 4; rd_cfg = 32'h1234_5678;
    REQ_ADDR[64 +: 32] = 32'h0000_0F10; REQ_WRITE[2] = 1'b0; REQ[2] = 1'b1;
    sb.push_back('{2, 32'h1234_5678, 1'b0});
    @(negedge PCLK); REQ[2] = 1'b0;
    n_chk++;
    if (PSEL !== 16'h8000 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin
      n_fail++; $display("FAIL rd_setup: psel=%h en=%b wr=%b want 8000/0/0", PSEL, PENABLE, PWRITE);
    end
    bad = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      @(negedge PCLK);
      if (PENABLE !== 1'b1 || PSEL !== 16'h8000 || PADDR !== 32'h0000_0F10 || DONE !== '0) bad = 1'b1;
    end
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL rd_wait_hold: access phase not stable or early DONE, got en=%b psel=%h done=%b", PENABLE, PSEL, DONE);
    end
    @(negedge PCLK);
    e = sb.pop_front();
    n_chk++;
    if (DONE !== (4'b1 << e.idx) || RDATA !== e.rdata || ERR !== e.err) begin
      n_fail++; $display("FAIL rd_done_c7: done=%b rdata=%h err=%b want idx %0d rdata=%h err=%b", DONE, RDATA, ERR, e.idx, e.rdata, e.err);
    end
    wait_cfg = 0;
    @(negedge PCLK);
  endtask

  // Pointer sits at 3 after the read; a simultaneous 0/1 request must wrap to 0.
  task automatic test_rr_wrap();
    exp_t e; int n;
    REQ_ADDR[0 +: 32] = 32'h0000_0100; REQ_WDATA[0 +: 32] = 32'h0000_0001; REQ_WRITE[0] = 1'b1;
    REQ_ADDR[32 +: 32] = 32'h0000_0200; REQ_WRITE[1] = 1'b0; rd_cfg = 32'hCAFE_0002;
    sb.push_back('{0, 32'h0, 1'b0});
    sb.push_back('{1, 32'hCAFE_0002, 1'b0});
    REQ[1:0] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      wait_done(20, n);
      n_chk++;
      if (DONE === '0) begin
        n_fail++; $display("FAIL wrap_timeout: no DONE for transfer %0d", k);
      end else begin
        e = sb.pop_front();
        if (DONE !== (4'b1 << e.idx) || RDATA !== e.rdata || ERR !== e.err) begin
          n_fail++; $display("FAIL wrap_done%0d: done=%b rdata=%h err=%b want idx %0d rdata=%h", k, DONE, RDATA, ERR, e.idx, e.rdata);
        end
        REQ = REQ & ~DONE;
      end
    end
    REQ = '0; sb.delete();
    @(negedge PCLK);
  endtask

  task automatic test_fairness();
    exp_t e; int n; int prev;
    PRESET = 1'b1; @(negedge PCLK); PRESET = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      REQ_ADDR[i*32 +: 32] = 32'(i) << 8; REQ_WDATA[i*32 +: 32] = 32'h100 + 32'(i);
    end
    REQ_WRITE = '1; rd_cfg = 32'hDEAD_BEEF;
    sb.push_back('{0, 32'h0, 1'b0}); sb.push_back('{1, 32'h0, 1'b0});
    sb.push_back('{2, 32'h0, 1'b0}); sb.push_back('{3, 32'h0, 1'b0});
    sb.push_back('{0, 32'h0, 1'b0});
    REQ = '1; prev = -1;
    for (int k = 0; k < 5; k++) begin
      wait_done(20, n);
      n_chk++;
      if (DONE === '0) begin
        n_fail++; $display("FAIL fair_timeout: no DONE for grant %0d", k);
      end else begin
        e = sb.pop_front();
        if (DONE !== (4'b1 << e.idx) || ERR !== 1'b0 || RDATA !== 32'h0 || e.idx == prev) begin
          n_fail++; $display("FAIL fair_grant%0d: done=%b err=%b rdata=%h want idx %0d", k, DONE, ERR, RDATA, e.idx);
        end
        prev = e.idx;
      end
    end
    REQ = '0; sb.delete();
    @(negedge PCLK);
    n_chk++;
    if (BUSY !== 1'b0) begin
      n_fail++; $display("FAIL fair_stop: busy=%b want 0", BUSY);
    end
  endtask

  task automatic test_slverr();
    exp_t e; int n;
    err_cfg = 1'b1;
    REQ_ADDR[32 +: 32] = 32'h0000_0A00; REQ_WDATA[32 +: 32] = 32'h0000_BEEF; REQ_WRITE[1] = 1'b1;
    sb.push_back('{1, 32'h0, 1'b1});
    REQ[1] = 1'b1; @(negedge PCLK); REQ[1] = 1'b0;
    wait_done(20, n);
    e = sb.pop_front();
    n_chk++;
    if (DONE !== (4'b1 << e.idx) || RDATA !== e.rdata || ERR !== e.err) begin
      n_fail++; $display("FAIL slverr_done: done=%b rdata=%h err=%b want idx %0d err=1", DONE, RDATA, ERR, e.idx);
    end
    err_cfg = 1'b0; rd_cfg = 32'h55AA_33CC;
    REQ_ADDR[96 +: 32] = 32'h0000_0C04; REQ_WRITE[3] = 1'b0;
    sb.push_back('{3, 32'h55AA_33CC, 1'b0});
    REQ[3] = 1'b1; @(negedge PCLK); REQ[3] = 1'b0;
    n_chk++;
    if (PSEL !== 16'h1000) begin
      n_fail++; $display("FAIL slverr_next_setup: psel=%h want 1000", PSEL);
    end
    wait_done(20, n);
    e = sb.pop_front();
    n_chk++;
    if (DONE !== (4'b1 << e.idx) || RDATA !== e.rdata || ERR !== e.err) begin
      n_fail++; $display("FAIL slverr_next: done=%b rdata=%h err=%b want idx %0d rdata=%h err=0", DONE, RDATA, ERR, e.idx, e.rdata);
    end
    @(negedge PCLK);
  endtask

  // Granting 1 moves the pointer to 2; only a working reset puts 0 ahead of 3.
  task automatic test_reset_mid_access();
    exp_t e; int n; bit bad;
    hang = 1'b1;
    REQ_ADDR[32 +: 32] = 32'h0000_0500; REQ_WRITE[1] = 1'b1;
    REQ[1] = 1'b1; @(negedge PCLK); REQ[1] = 1'b0;
    @(negedge PCLK);
    n_chk++;
    if (PENABLE !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_access: en=%b want 1", PENABLE);
    end
    PRESET = 1'b1; @(negedge PCLK); PRESET = 1'b0; hang = 1'b0;
    n_chk++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, DONE, RDATA, ERR, BUSY} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: psel=%h en=%b wr=%b addr=%h done=%b busy=%b want all 0", PSEL, PENABLE, PWRITE, PADDR, DONE, BUSY);
    end
    bad = 1'b0;
    repeat (4) begin @(negedge PCLK); if (DONE !== '0 || BUSY !== 1'b0) bad = 1'b1; end
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL rst_no_done: done=%b busy=%b want 0 after reset", DONE, BUSY);
    end
    REQ_ADDR[0 +: 32] = 32'h0000_0200; REQ_ADDR[96 +: 32] = 32'h0000_0300;
    REQ_WRITE[0] = 1'b1; REQ_WRITE[3] = 1'b1;
    sb.push_back('{0, 32'h0, 1'b0}); sb.push_back('{3, 32'h0, 1'b0});
    REQ = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      wait_done(20, n);
      n_chk++;
      if (DONE === '0) begin
        n_fail++; $display("FAIL rst_prio_timeout: no DONE for transfer %0d", k);
      end else begin
        e = sb.pop_front();
        if (DONE !== (4'b1 << e.idx) || ERR !== 1'b0) begin
          n_fail++; $display("FAIL rst_prio%0d: done=%b err=%b want idx %0d", k, DONE, ERR, e.idx);
        end
        REQ = REQ & ~DONE;
      end
    end
    REQ = '0; sb.delete();
    @(negedge PCLK);
  endtask

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e; int acc;
    hang = 1'b1; rd_cfg = 32'hFFFF_0000;
    REQ_ADDR[64 +: 32] = 32'h0000_0700; REQ_WRITE[2] = 1'b0;
    sb.push_back('{2, 32'h0, 1'b1});
    REQ[2] = 1'b1; @(negedge PCLK); REQ[2] = 1'b0;
    acc = 0;
    for (int c = 0; c < 40 && DONE === '0; c++) begin
      @(negedge PCLK);
      if (PENABLE === 1'b1) acc++;
    end
    n_chk++;
    if (acc !== 8) begin
      n_fail++; $display("FAIL to_cycles: got %0d access cycles want 8", acc);
    end
    e = sb.pop_front();
    n_chk++;
    if (DONE !== (4'b1 << e.idx) || RDATA !== e.rdata || ERR !== e.err) begin
      n_fail++; $display("FAIL to_done: done=%b rdata=%h err=%b want idx %0d rdata=0 err=1", DONE, RDATA, ERR, e.idx);
    end
    hang = 1'b0;
    @(negedge PCLK);
  endtask
`else
  task automatic test_no_timeout();
    exp_t e; int n; bit bad;
    hang = 1'b1;
    REQ_ADDR[64 +: 32] = 32'h0000_0700; REQ_WRITE[2] = 1'b0;
    REQ[2] = 1'b1; @(negedge PCLK); REQ[2] = 1'b0;
    bad = 1'b0;
    repeat (40) begin @(negedge PCLK); if (DONE !== '0 || PENABLE !== 1'b1) bad = 1'b1; end
    n_chk++;
    if (bad) begin
      n_fail++; $display("FAIL nto_hold: done=%b en=%b want access held with no DONE", DONE, PENABLE);
    end
    rd_cfg = 32'h0BAD_F00D; hang = 1'b0;
    sb.push_back('{2, 32'h0BAD_F00D, 1'b0});
    wait_done(10, n);
    e = sb.pop_front();
    n_chk++;
    if (DONE !== (4'b1 << e.idx) || RDATA !== e.rdata || ERR !== e.err) begin
      n_fail++; $display("FAIL nto_done: done=%b rdata=%h err=%b want idx %0d rdata=%h", DONE, RDATA, ERR, e.idx, e.rdata);
    end
    @(negedge PCLK);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_rr_wrap();
    test_fairness();
    test_slverr();
    test_reset_mid_access();
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
